// File: rtl/jet_pkg.sv
// Shared jet-finder types and constants for the zbin histogram path.
package jet_pkg;

  localparam int unsigned ZBIN_W = 4;
  localparam int unsigned NZBINS = 6;
  localparam logic [ZBIN_W-1:0] ZBIN_NONE = {ZBIN_W{1'b1}};

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    SECOND = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Any index at or above NZBINS (including ZBIN_NONE) is not a real bin.
  function automatic logic zbin_valid(input logic [ZBIN_W-1:0] z);
    return z < ZBIN_W'(NZBINS);
  endfunction

endpackage

// File: rtl/zbin_out_reg.sv
// Valid/ready output register for RAM commands; fields hold while stalled.
module zbin_out_reg
  import jet_pkg::*;
#(
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              cmd,
  input  logic [ZBIN_W-1:0] zbin,
  input  logic [DATA_W-1:0] data,
  input  logic              eoe,
  input  logic              out_ready,
  output logic              free_c,
  output logic              out_valid,
  output logic              out_cmd,
  output logic [ZBIN_W-1:0] out_zbin,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eoe
);

  logic              valid_q, valid_d;
  logic              cmd_q, cmd_d;
  logic [ZBIN_W-1:0] zbin_q, zbin_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              eoe_q, eoe_d;

  assign free_c = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    cmd_d   = cmd_q;
    zbin_d  = zbin_q;
    data_d  = data_q;
    eoe_d   = eoe_q;
    if (free_c) begin
      valid_d = load;
      if (load) begin
        cmd_d  = cmd;
        zbin_d = zbin;
        data_d = data;
        eoe_d  = eoe;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      cmd_q   <= 1'b0;
      zbin_q  <= '0;
      data_q  <= '0;
      eoe_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      zbin_q  <= zbin_d;
      data_q  <= data_d;
      eoe_q   <= eoe_d;
    end
  end

  assign out_valid = valid_q;
  assign out_cmd   = cmd_q;
  assign out_zbin  = zbin_q;
  assign out_data  = data_q;
  assign out_eoe   = eoe_q;

endmodule

// File: rtl/zbin_write_scheduler.sv
// Serialises dual-zbin tracks into one RAM write per cycle, then sweeps
// every bin with a readout/clear command at end of event.
module zbin_write_scheduler
  import jet_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ZBIN_W-1:0] in_zbin1,
  input  logic [ZBIN_W-1:0] in_zbin2,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_cmd,
  output logic [ZBIN_W-1:0] out_zbin,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eoe,
  output logic              evt_done,
  output logic [CNT_W-1:0]  drop_cnt
);

  state_e            state_q, state_d;
  logic [ZBIN_W-1:0] pend_zbin_q, pend_zbin_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              pend_last_q, pend_last_d;
  logic [ZBIN_W-1:0] bin_cnt_q, bin_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              evt_done_q, evt_done_d;

  logic              out_free;
  logic              ld, ld_cmd, ld_eoe;
  logic [ZBIN_W-1:0] ld_zbin;
  logic [DATA_W-1:0] ld_data;
  logic [CNT_W-1:0]  drop_base;
  logic              z1_ok, z2_ok, final_acc;

  assign z1_ok     = zbin_valid(in_zbin1);
  assign z2_ok     = zbin_valid(in_zbin2);
  assign final_acc = out_valid && out_ready && out_eoe;

  always_comb begin
    state_d     = state_q;
    pend_zbin_d = pend_zbin_q;
    pend_data_d = pend_data_q;
    pend_last_d = pend_last_q;
    bin_cnt_d   = bin_cnt_q;
    evt_done_d  = final_acc;
    in_ready    = 1'b0;
    ld          = 1'b0;
    ld_cmd      = CMD_WRITE;
    ld_zbin     = '0;
    ld_data     = '0;
    ld_eoe      = 1'b0;
    // The count reported with evt_done is cleared on the following cycle.
    drop_base   = evt_done_q ? '0 : drop_cnt_q;
    drop_cnt_d  = drop_base;

    case (state_q)
      ACCEPT: begin
        in_ready = out_free;
        if (in_valid && out_free) begin
          if (z1_ok) begin
            ld      = 1'b1;
            ld_zbin = in_zbin1;
            ld_data = in_data;
            if (z2_ok) begin
              pend_zbin_d = in_zbin2;
              pend_data_d = in_data;
              pend_last_d = in_last;
              state_d     = SECOND;
            end
          end else if (z2_ok) begin
            ld      = 1'b1;
            ld_zbin = in_zbin2;
            ld_data = in_data;
          end else if (drop_base != '1) begin
            drop_cnt_d = drop_base + CNT_W'(1);
          end
          if (in_last && !(z1_ok && z2_ok)) begin
            state_d   = FLUSH;
            bin_cnt_d = '0;
          end
        end
      end
      SECOND: begin
        if (out_free) begin
          ld        = 1'b1;
          ld_zbin   = pend_zbin_q;
          ld_data   = pend_data_q;
          state_d   = pend_last_q ? FLUSH : ACCEPT;
          bin_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (bin_cnt_q < ZBIN_W'(NZBINS)) begin
          if (out_free) begin
            ld        = 1'b1;
            ld_cmd    = CMD_READ;
            ld_zbin   = bin_cnt_q;
            ld_eoe    = (bin_cnt_q == ZBIN_W'(NZBINS - 1));
            bin_cnt_d = bin_cnt_q + ZBIN_W'(1);
          end
        end else if (final_acc) begin
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACCEPT;
      pend_zbin_q <= '0;
      pend_data_q <= '0;
      pend_last_q <= 1'b0;
      bin_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      evt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_zbin_q <= pend_zbin_d;
      pend_data_q <= pend_data_d;
      pend_last_q <= pend_last_d;
      bin_cnt_q   <= bin_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      evt_done_q  <= evt_done_d;
    end
  end

  zbin_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (ld),
    .cmd       (ld_cmd),
    .zbin      (ld_zbin),
    .data      (ld_data),
    .eoe       (ld_eoe),
    .out_ready (out_ready),
    .free_c    (out_free),
    .out_valid (out_valid),
    .out_cmd   (out_cmd),
    .out_zbin  (out_zbin),
    .out_data  (out_data),
    .out_eoe   (out_eoe)
  );

  assign evt_done = evt_done_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_zbin_write_scheduler.sv
// Scoreboard bench for zbin_write_scheduler: table-driven tracks plus
// hand-written timing, stall, saturation and reset sequences.
module tb_zbin_write_scheduler;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned CNT_W  = 8;
  localparam logic [3:0]  NONE   = 4'hF;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, in_last;
  logic [DATA_W-1:0] in_data;
  logic [3:0]        in_zbin1, in_zbin2;
  logic              out_valid, out_ready, out_cmd, out_eoe, evt_done;
  logic [3:0]        out_zbin;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  drop_cnt;

  zbin_write_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_zbin1(in_zbin1), .in_zbin2(in_zbin2), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
    .out_zbin(out_zbin), .out_data(out_data), .out_eoe(out_eoe),
    .evt_done(evt_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              cmd;
    logic [3:0]        zbin;
    logic [DATA_W-1:0] data;
    logic              eoe;
  } cmd_t;

  // Track stimulus with the hand-derived WRITE bins it must produce (NONE = no write).
  typedef struct {
    logic [3:0] z1;
    logic [3:0] z2;
    logic       last;
    logic [3:0] w0;
    logic [3:0] w1;
  } vec_t;

  cmd_t sb[$];
  int   drop_q[$];
  int   acc_cyc[$];
  int   xfer_cyc[$];
  vec_t vecs[10];
  int   pass_cnt = 0, chk_cnt = 0;
  int   cyc = 0, evt_cnt = 0, evt_drops = 0, last_eoe_cyc = 0;
  int   ready_mode = 0;
  bit   prev_evt = 0, prev_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    chk_cnt++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic bit bin_ok(input logic [3:0] z);
    return z < 4'd6;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) out_ready = ~out_ready;
    else out_ready = 1'b1;
  end

  // Output monitor: compares every accepted command and every evt_done pulse.
  always @(negedge clk) begin
    cmd_t e;
    bit   dropping;
    if (reset) begin
      prev_evt  = 0;
      prev_drop = 0;
    end else begin
      if (out_valid && out_ready) begin
        xfer_cyc.push_back(cyc);
        if (out_eoe) last_eoe_cyc = cyc;
        if (sb.size() == 0) fail("unexpected_cmd");
        else begin
          e = sb.pop_front();
          check("cmd_word", 32'({out_cmd, out_eoe, out_zbin, out_data}),
                32'({e.cmd, e.eoe, e.zbin, e.data}));
        end
      end
      dropping = in_valid && in_ready && !bin_ok(in_zbin1) && !bin_ok(in_zbin2);
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (prev_evt) check("drop_cnt_clear", 32'(drop_cnt), prev_drop ? 32'd1 : 32'd0);
      if (evt_done) begin
        evt_cnt++;
        check("evt_done_timing", 32'(cyc - 1), 32'(last_eoe_cyc));
        if (drop_q.size() == 0) fail("spurious_evt_done");
        else check("drop_cnt", 32'(drop_cnt), 32'(drop_q.pop_front()));
      end
      prev_evt  = evt_done;
      prev_drop = dropping;
    end
  end

  task automatic send(input vec_t v);
    logic [DATA_W-1:0] d;
    logic              acc;
    int                n;
    cmd_t              c;
    d = DATA_W'($urandom);
    c.cmd = 1'b0; c.data = d; c.eoe = 1'b0;
    if (v.w0 != NONE) begin c.zbin = v.w0; sb.push_back(c); end
    if (v.w1 != NONE) begin c.zbin = v.w1; sb.push_back(c); end
    if (v.w0 == NONE) evt_drops = (evt_drops < 255) ? evt_drops + 1 : 255;
    if (v.last) begin
      for (int b = 0; b < 6; b++) begin
        c.cmd = 1'b1; c.zbin = 4'(b); c.data = '0; c.eoe = (b == 5);
        sb.push_back(c);
      end
      drop_q.push_back(evt_drops);
      evt_drops = 0;
    end
    in_valid = 1'b1; in_data = d; in_zbin1 = v.z1; in_zbin2 = v.z2; in_last = v.last;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    if (!acc) fail("in_ready_timeout");
    in_valid = 1'b0;
  endtask

  task automatic mk(input logic [3:0] z1, input logic [3:0] z2, input logic last, output vec_t v);
    v.z1 = z1; v.z2 = z2; v.last = last;
    v.w0 = bin_ok(z1) ? z1 : (bin_ok(z2) ? z2 : NONE);
    v.w1 = (bin_ok(z1) && bin_ok(z2)) ? z2 : NONE;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || drop_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size() + drop_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int   evt_before, n;
    vec_t v;
    vecs[0] = '{z1: 4'd2, z2: NONE, last: 1'b0, w0: 4'd2, w1: NONE};
    vecs[1] = '{z1: 4'd0, z2: 4'd1, last: 1'b0, w0: 4'd0, w1: 4'd1};
    vecs[2] = '{z1: 4'd5, z2: NONE, last: 1'b0, w0: 4'd5, w1: NONE};
    vecs[3] = '{z1: NONE, z2: 4'd3, last: 1'b1, w0: 4'd3, w1: NONE};
    vecs[4] = '{z1: NONE, z2: NONE, last: 1'b1, w0: NONE, w1: NONE};
    vecs[5] = '{z1: 4'd2, z2: 4'd3, last: 1'b1, w0: 4'd2, w1: 4'd3};
    vecs[6] = '{z1: 4'd1, z2: NONE, last: 1'b0, w0: 4'd1, w1: NONE};
    vecs[7] = '{z1: 4'd4, z2: 4'd4, last: 1'b0, w0: 4'd4, w1: 4'd4};
    vecs[8] = '{z1: 4'd7, z2: 4'd2, last: 1'b0, w0: 4'd2, w1: NONE};
    vecs[9] = '{z1: 4'd6, z2: 4'd0, last: 1'b1, w0: 4'd0, w1: NONE};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_zbin1 = NONE; in_zbin2 = NONE;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({out_valid, out_cmd, out_eoe, evt_done, out_zbin, out_data}), 32'd0);
    check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Single/dual-bin timing: one-cycle latency, back-to-back writes, SECOND stall.
    acc_cyc.delete(); xfer_cyc.delete();
    for (int i = 0; i < 4; i++) send(vecs[i]);
    drain();
    check("latency_first_write", 32'(xfer_cyc[0] - acc_cyc[0]), 32'd1);
    check("write_b2b_1", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd1);
    check("write_b2b_2", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd1);
    check("accept_b2b", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    check("second_stall", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);

    // Empty event: full sweep, back-to-back READs, drop count 1.
    xfer_cyc.delete();
    evt_before = evt_cnt;
    send(vecs[4]);
    drain();
    check("sweep_len", 32'(xfer_cyc.size()), 32'd6);
    check("sweep_b2b", 32'(xfer_cyc[5] - xfer_cyc[0]), 32'd5);
    check("evt_once_empty", 32'(evt_cnt - evt_before), 32'd1);

    // Dual-bin track that ends the event.
    evt_before = evt_cnt;
    send(vecs[5]);
    drain();
    check("evt_once_dual", 32'(evt_cnt - evt_before), 32'd1);

    // Stalling RAM port.
    ready_mode = 1;
    evt_before = evt_cnt;
    for (int i = 6; i < 10; i++) send(vecs[i]);
    drain();
    ready_mode = 0;
    check("evt_once_stall", 32'(evt_cnt - evt_before), 32'd1);

    // Random single/dual mixes under stall.
    ready_mode = 1;
    for (int i = 0; i < 20; i++) begin
      mk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), i == 19, v);
      send(v);
    end
    drain();
    ready_mode = 0;

    // Drop counter saturation.
    evt_before = evt_cnt;
    mk(NONE, NONE, 1'b0, v);
    for (int i = 0; i < 300; i++) send(v);
    mk(NONE, NONE, 1'b1, v);
    send(v);
    drain();
    check("evt_once_sat", 32'(evt_cnt - evt_before), 32'd1);

    // Reset in the middle of the sweep.
    evt_before = evt_cnt;
    mk(4'd1, NONE, 1'b1, v);
    send(v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_cmd && out_zbin == 4'd3) && n < 100);
    if (n >= 100) fail("flush_bin3_timeout");
    #2;
    reset = 1'b1;
    #1;
    check("midreset_outputs", 32'({out_valid, out_cmd, out_eoe, evt_done, out_zbin, out_data}), 32'd0);
    check("midreset_drop_cnt", 32'(drop_cnt), 32'd0);
    sb.delete(); drop_q.delete(); evt_drops = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midreset_no_evt", 32'(evt_cnt - evt_before), 32'd0);
    check("midreset_idle", 32'(out_valid), 32'd0);
    mk(4'd4, NONE, 1'b1, v);
    send(v);
    drain();
    check("post_reset_evt", 32'(evt_cnt - evt_before), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
